// File: rtl/ili_spi_tx_if.sv
`default_nettype none
// ============================================================================
// Module   : ili_spi_tx_if
// Brief    : Request/response and SPI pin bundle between the command
//            controller (master) and the ILI9341 SPI serializer (slave).
// Revision : 1.0
// ============================================================================
interface ili_spi_tx_if #(
    parameter int DW = 8
);
    logic          send;
    logic [DW-1:0] data;
    logic          dc;
    logic          sent;
    logic          shift_dis;
    logic          sck;
    logic          mosi;
    logic          dc_o;

    modport master (
        output send, data, dc,
        input  sent, shift_dis, sck, mosi, dc_o
    );

    modport slave (
        input  send, data, dc,
        output sent, shift_dis, sck, mosi, dc_o
    );
endinterface
`default_nettype wire

// File: rtl/ili_spi_tx.sv
`default_nettype none
// ============================================================================
// Module   : ili_spi_tx
// Brief    : SPI mode-0 MSB-first word serializer for the ILI9341 link.
//            Optional completed-word counter: ILI_SPI_TX_BYTE_CNT_EN.
// Revision : 1.0
// ============================================================================
module ili_spi_tx #(
    parameter int DW      = 8,
    parameter int CLK_DIV = 2
) (
    input  wire         clk,
    input  wire         rst,
    ili_spi_tx_if.slave bus
`ifdef ILI_SPI_TX_BYTE_CNT_EN
    ,
    output wire [15:0]  byte_cnt
`endif
);
    localparam int               c_DCW      = $clog2(CLK_DIV) + 1;
    localparam int               c_BCW      = $clog2(DW);
    localparam logic [c_DCW-1:0] c_DIV_LAST = c_DCW'(CLK_DIV - 1);
    localparam logic [c_BCW-1:0] c_BIT_TOP  = c_BCW'(DW - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_LOAD  = 2'd1,
        S_SHIFT = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t           r_state;
    state_t           w_state_next;
    logic [DW-1:0]    r_shreg;
    logic [c_BCW-1:0] r_bit_cnt;
    logic [c_DCW-1:0] r_div_cnt;
    logic             r_sck;
    logic             r_mosi;
    logic             r_dc;
    logic             r_sent;
    logic             r_busy;
    logic             w_half_end;

    assign w_half_end = (r_div_cnt == c_DIV_LAST);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE:  if (bus.send) w_state_next = S_LOAD;
            S_LOAD:  w_state_next = S_SHIFT;
            // Word ends at the falling edge that follows the last bit's high half
            S_SHIFT: if (w_half_end && r_sck && (r_bit_cnt == '0)) w_state_next = S_DONE;
            S_DONE:  w_state_next = S_IDLE;
            default: w_state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_shreg   <= '0;
            r_bit_cnt <= '0;
            r_div_cnt <= '0;
            r_sck     <= 1'b0;
            r_mosi    <= 1'b0;
            r_dc      <= 1'b1;
            r_sent    <= 1'b0;
            r_busy    <= 1'b0;
        end else begin
            r_sent <= (w_state_next == S_DONE);
            r_busy <= (w_state_next != S_IDLE);
            case (r_state)
                S_LOAD: begin
                    r_shreg   <= bus.data;
                    r_dc      <= bus.dc;
                    r_mosi    <= bus.data[DW-1];
                    r_sck     <= 1'b0;
                    r_bit_cnt <= c_BIT_TOP;
                    r_div_cnt <= '0;
                end
                S_SHIFT: begin
                    if (w_half_end) begin
                        r_div_cnt <= '0;
                        if (!r_sck) begin
                            r_sck <= 1'b1;
                        end else begin
                            r_sck <= 1'b0;
                            if (r_bit_cnt != '0) begin
                                r_shreg   <= {r_shreg[DW-2:0], 1'b0};
                                r_mosi    <= r_shreg[DW-2];
                                r_bit_cnt <= r_bit_cnt - c_BCW'(1);
                            end
                        end
                    end else begin
                        r_div_cnt <= r_div_cnt + c_DCW'(1);
                    end
                end
                default: begin
                    r_sck <= 1'b0;
                end
            endcase
        end
    end

    assign bus.sck       = r_sck;
    assign bus.mosi      = r_mosi;
    assign bus.dc_o      = r_dc;
    assign bus.sent      = r_sent;
    assign bus.shift_dis = r_busy;

`ifdef ILI_SPI_TX_BYTE_CNT_EN
    logic [15:0] r_byte_cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_byte_cnt <= '0;
        end else if (r_state == S_DONE) begin
            r_byte_cnt <= r_byte_cnt + 16'd1;
        end
    end

    assign byte_cnt = r_byte_cnt;
`endif

endmodule
`default_nettype wire
